cp0_exc_ctrl: RTL and testbench

- Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline; evaluates exceptions and interrupts at the M stage.
- Drives the fetch unit's exception redirect request (PC forced to handler 0x0000_4180 on the next clock) and supplies EPC for eret redirection.
- Holds the SR, Cause, EPC and PRId registers; accessed by mfc0/mtc0.

---
 rtl/cp0_exc_ctrl.sv | 101 ++++++++++
 tb/tb_cp0_exc_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller: evaluates interrupts and exceptions
// at the M stage, holds SR/Cause/EPC/PRId and services mfc0/mtc0 accesses.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID   = 32'h2021_0001,
  parameter logic [5:0]  IM_RST = 6'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        valid_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic        eret_m,
  input  logic [5:0]  hw_int,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  output logic        req,
  output logic [31:0] epc
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic        bd_q;
  logic [5:0]  ip_q;
  logic [4:0]  exccode_q;
  logic [31:0] epc_q;

  logic        int_req;
  logic        exc_req;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] epc_d;
  logic [4:0]  exccode_d;

  assign int_req = valid_m & ie_q & ~exl_q & (|(hw_int & im_q));
  assign exc_req = valid_m & ~exl_q & (exc_code_m != 5'd0);
  assign req     = int_req | exc_req;

  // An mtc0 that coincides with req belongs to the flushed instruction.
  assign wr_sr  = we & ~req & (waddr == ADDR_SR);
  assign wr_epc = we & ~req & (waddr == ADDR_EPC);

  assign epc_d     = bd_m ? (pc_m - 32'd4) : pc_m;
  assign exccode_d = int_req ? 5'd0 : exc_code_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q      <= IM_RST;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= 6'd0;
      exccode_q <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      ip_q <= hw_int;
      if (req) begin
        exl_q     <= 1'b1;
        bd_q      <= bd_m;
        exccode_q <= exccode_d;
        epc_q     <= epc_d;
      end else begin
        if (wr_sr) begin
          im_q  <= wdata[15:10];
          exl_q <= wdata[1];
          ie_q  <= wdata[0];
        end
        if (wr_epc) begin
          epc_q <= wdata;
        end
        // eret overrides the EXL value an mtc0 may have written this cycle
        if (eret_m) begin
          exl_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (raddr)
      ADDR_SR:    rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
      ADDR_CAUSE: rdata = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
      ADDR_EPC:   rdata = epc_q;
      ADDR_PRID:  rdata = PRID;
      default:    rdata = 32'd0;
    endcase
  end

  assign epc = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: linear sequence of hand-computed vectors
// checked with immediate assertions.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID = 32'h2021_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_m;
  logic        valid_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic [5:0]  hw_int;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] epc;

  int vectors = 0;
  int miscompares = 0;

  cp0_exc_ctrl #(.PRID(PRID), .IM_RST(6'h00)) dut (
    .clk(clk), .reset(reset), .pc_m(pc_m), .valid_m(valid_m), .bd_m(bd_m),
    .exc_code_m(exc_code_m), .eret_m(eret_m), .hw_int(hw_int), .we(we),
    .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata), .req(req),
    .epc(epc)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    raddr = addr;
    #1;
    check32(tag, rdata, exp);
  endtask

  task automatic chk_req(input logic exp, input string tag);
    #1;
    check32(tag, {31'd0, req}, {31'd0, exp});
  endtask

  initial begin
    reset = 1'b1; pc_m = 32'd0; valid_m = 1'b0; bd_m = 1'b0; exc_code_m = 5'd0;
    eret_m = 1'b0; hw_int = 6'd0; we = 1'b0; waddr = 5'd0; wdata = 32'd0; raddr = 5'd0;
    tick(); tick();
    reset = 1'b0;

    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc_reg");
    rd(5'd15, PRID, "rst_prid");
    chk_req(1'b0, "rst_req");
    check32("rst_epc_out", epc, 32'h0);

    we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0401;
    tick();
    we = 1'b0;
    rd(5'd12, 32'h0000_0401, "mtc0_sr");

    hw_int = 6'b000001; valid_m = 1'b1; pc_m = 32'h3010;
    chk_req(1'b1, "int_req");
    tick();
    check32("int_epc", epc, 32'h3010);
    rd(5'd13, 32'h0000_0400, "int_cause");
    rd(5'd12, 32'h0000_0403, "int_sr_exl");
    chk_req(1'b0, "int_exl_blocks");
    valid_m = 1'b0;

    hw_int = 6'd0; we = 1'b1; waddr = 5'd12; wdata = 32'h0;
    tick();
    we = 1'b0;
    rd(5'd12, 32'h0, "sr_clear");

    exc_code_m = 5'd12; bd_m = 1'b1; pc_m = 32'h3024; valid_m = 1'b1;
    chk_req(1'b1, "exc_req");
    tick();
    check32("exc_bd_epc", epc, 32'h3020);
    rd(5'd13, 32'h8000_0030, "exc_cause");
    rd(5'd12, 32'h0000_0002, "exc_sr_exl");

    exc_code_m = 5'd4; bd_m = 1'b0; pc_m = 32'h3050;
    chk_req(1'b0, "exl_masks_exc");
    tick();
    check32("exl_epc_hold", epc, 32'h3020);
    rd(5'd13, 32'h8000_0030, "exl_cause_hold");
    exc_code_m = 5'd0; valid_m = 1'b0; eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    rd(5'd12, 32'h0, "eret_clears_exl");

    we = 1'b1; waddr = 5'd14; wdata = 32'hDEAD_0000;
    exc_code_m = 5'd10; pc_m = 32'h3100; valid_m = 1'b1;
    chk_req(1'b1, "exc_mtc0_req");
    tick();
    we = 1'b0; exc_code_m = 5'd0; valid_m = 1'b0;
    check32("mtc0_dropped_epc", epc, 32'h3100);
    rd(5'd13, 32'h0000_0028, "exc10_cause");

    we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0403; eret_m = 1'b1;
    tick();
    we = 1'b0; eret_m = 1'b0;
    rd(5'd12, 32'h0000_0401, "mtc0_eret_sr");

    hw_int = 6'b000001; exc_code_m = 5'd12; pc_m = 32'h3200; valid_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_req(1'b0, "invalid_defers");
      tick();
    end
    valid_m = 1'b1;
    chk_req(1'b1, "deferred_int_req");
    tick();
    valid_m = 1'b0; exc_code_m = 5'd0;
    check32("deferred_epc", epc, 32'h3200);
    rd(5'd13, 32'h0000_0400, "int_over_exc_cause");
    rd(5'd12, 32'h0000_0403, "deferred_sr");

    eret_m = 1'b1;
    tick();
    valid_m = 1'b1; pc_m = 32'h3300;
    chk_req(1'b1, "eret_req_req");
    tick();
    eret_m = 1'b0; valid_m = 1'b0;
    rd(5'd12, 32'h0000_0403, "req_beats_eret");
    check32("req_beats_eret_epc", epc, 32'h3300);

    eret_m = 1'b1; hw_int = 6'd0;
    tick();
    eret_m = 1'b0;
    exc_code_m = 5'd8; bd_m = 1'b1; pc_m = 32'h0; valid_m = 1'b1;
    chk_req(1'b1, "wrap_req");
    tick();
    exc_code_m = 5'd0; bd_m = 1'b0; valid_m = 1'b0;
    check32("wrap_epc", epc, 32'hFFFF_FFFC);
    rd(5'd13, 32'h8000_0020, "wrap_cause");

    we = 1'b1; waddr = 5'd13; wdata = 32'hFFFF_FFFF;
    tick();
    waddr = 5'd15; wdata = 32'h0;
    tick();
    we = 1'b0;
    rd(5'd13, 32'h8000_0020, "cause_ro");
    rd(5'd15, PRID, "prid_ro");
    rd(5'd7, 32'h0, "unmapped_read");

    hw_int = 6'b000010;
    we = 1'b1; waddr = 5'd14; wdata = 32'h1234;
    exc_code_m = 5'd4; valid_m = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; we = 1'b0; exc_code_m = 5'd0; valid_m = 1'b0; hw_int = 6'd0;
    rd(5'd12, 32'h0, "midrst_sr");
    rd(5'd13, 32'h0, "midrst_cause");
    check32("midrst_epc", epc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
